lsu_stage: RTL and testbench
============================

LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, datapath/address width; TIMEOUT_CYCLES, 16, max BUSY cycles waiting for MemReady (legal range 1..255).
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ALUResult  in  32  effective address from the ALU.
- WriteData  in  32  store data (rs2).
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- funct3  in  3  access size/sign.
- Stall  out  1  freeze upstream pipeline.
- ReadData  out  32  extended load result.
- LoadValid  out  1  load-complete pulse.
- MisalignErr  out  1  misaligned-access pulse.
- BusErr  out  1  timeout pulse.
- MemAddr  out  32  word-aligned address.
- MemWData  out  32  lane-replicated store data.
- MemBE  out  4  byte enables.
- MemWE  out  1  write strobe.
- MemReq  out  1  request valid.
- MemReady  in  1  memory accept/complete.
- MemRData  in  32  memory read word.

Function
REQ-003 The FSM SHALL have exactly three states, IDLE, BUSY and RESP, and SHALL reset to IDLE.
REQ-004 IDLE with MemRead|MemWrite high SHALL accept the access: register address, data and funct3, and go to BUSY; MemWrite SHALL win if both are high.
REQ-005 Stall SHALL be high combinationally in the accept cycle and in every BUSY cycle, and low in RESP and idle IDLE.
REQ-006 MemReq SHALL be high only in BUSY; MemAddr, MemWData, MemBE and MemWE SHALL remain stable while MemReq is high.
REQ-007 BUSY with MemReady high SHALL transition to RESP; MemReady outside BUSY SHALL be ignored.
REQ-008 RESP SHALL last one cycle and then return to IDLE; requests present during RESP SHALL NOT be accepted.
REQ-009 Minimum latency: accept at T, MemReq at T+1, RESP at T+2 when MemReady is high at T+1.
REQ-010 Access sizes SHALL be: funct3 000 = byte signed, 001 = half signed, 010 = word, 100 = byte unsigned, 101 = half unsigned; 011, 110 and 111 SHALL be treated as word.
REQ-011 MemBE SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-012 MemWData SHALL be: byte {4{WriteData[7:0]}}; half {2{WriteData[15:0]}}; word WriteData.
REQ-013 MemAddr SHALL be {addr[31:2],2'b00}.
REQ-014 On a load in RESP, ReadData SHALL register the lane selected by addr from MemRData, sign- or zero-extended, and LoadValid SHALL pulse high.
REQ-015 ReadData SHALL hold its value until the next load RESP; stores SHALL NOT alter it.
REQ-016 A BUSY cycle counter SHALL clear on accept; if it reaches TIMEOUT_CYCLES without MemReady, the FSM SHALL drop MemReq and enter RESP.
REQ-017 In a timeout RESP, BusErr SHALL pulse high, ReadData SHALL load 0 and LoadValid SHALL stay low.
REQ-018 MemReady arriving in the same cycle as the timeout SHALL complete the access normally with no BusErr.

Reset
REQ-019 rst high SHALL asynchronously force: state IDLE, counter 0, ReadData 0, and Stall, LoadValid, MisalignErr, BusErr, MemReq, MemWE, MemBE, MemAddr and MemWData all 0.
REQ-020 Reset asserted mid-BUSY SHALL abandon the access with MemReq low immediately and no error pulse after release.

Configuration
REQ-021 With macro LSU_MISALIGN_TRAP_EN defined, a misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) SHALL NOT assert MemReq.
REQ-022 Such an access SHALL go accept -> RESP directly, pulse MisalignErr, and load 0 into ReadData for loads with LoadValid low.
REQ-023 Without LSU_MISALIGN_TRAP_EN, the offending low address bits SHALL be ignored (access treated as aligned) and MisalignErr SHALL be tied 0.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- LB at 0x1003, MemRData=0x80FF_FFFF, MemReady at first BUSY cycle -> MemBE=1000, ReadData=0xFFFF_FF80, LoadValid at T+2, Stall high T..T+1.
- LHU at 0x2002, MemRData=0xBEEF_1234, MemReady after 3 cycles -> MemBE=1100, ReadData=0x0000_BEEF, Stall high 4 cycles.
- SB 0x1234_56AB at 0x0001 -> MemWE=1, MemBE=0010, MemWData=0xABAB_ABAB, ReadData unchanged.
- LW at 0x0004, MemReady never high, TIMEOUT_CYCLES=16 -> MemReq high 16 cycles, BusErr pulse, ReadData=0.
- LW at 0x0006 with LSU_MISALIGN_TRAP_EN -> no MemReq, MisalignErr pulse; without the macro -> MemAddr=0x0004, normal load.
- rst asserted on 2nd BUSY cycle of an SW -> MemReq low same cycle, state IDLE, no BusErr after release.

Source files
------------

// File: rtl/lsu_stage.sv
// Load/store unit stage: one outstanding memory access, byte-lane steering, load extension and BUSY timeout.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word accesses instead of issuing them).
module lsu_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ALUResult,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [2:0]            funct3,
   output logic                  Stall,
   output logic [DATA_WIDTH-1:0] ReadData,
   output logic                  LoadValid,
   output logic                  MisalignErr,
   output logic                  BusErr,
   output logic [DATA_WIDTH-1:0] MemAddr,
   output logic [DATA_WIDTH-1:0] MemWData,
   output logic [3:0]            MemBE,
   output logic                  MemWE,
   output logic                  MemReq,
   input  logic                  MemReady,
   input  logic [DATA_WIDTH-1:0] MemRData
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   // Picks the addressed lane out of the returned word and sign/zero extends it.
   function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  extend_load = {{24{b[7]}}, b};
         3'b001:  extend_load = {{16{h[15]}}, h};
         3'b100:  extend_load = {24'd0, b};
         3'b101:  extend_load = {16'd0, h};
         default: extend_load = word;
      endcase
   endfunction

   logic [1:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  lane_q;
   logic [2:0]  f3_q;
   logic        load_q;
   logic [31:0] rdata_q, addr_q, wdata_q;
   logic [3:0]  be_q;
   logic        we_q, lv_q, buserr_q;
   logic        req_s, accept_s, misalign_s, done_s, timeout_s;
   logic [3:0]  be_s;
   logic [31:0] wdata_s;

   assign req_s     = MemRead | MemWrite;
   assign accept_s  = (state_q == IDLE) && req_s;
   assign done_s    = (state_q == BUSY) && MemReady;
   assign timeout_s = (state_q == BUSY) && !MemReady && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

   // Byte enables and lane-replicated store data for the incoming access.
   always_comb begin
      be_s    = 4'b1111;
      wdata_s = WriteData;
      case (funct3)
         3'b000, 3'b100: begin
            be_s    = 4'b0001 << ALUResult[1:0];
            wdata_s = {4{WriteData[7:0]}};
         end
         3'b001, 3'b101: begin
            be_s    = 4'b0011 << {ALUResult[1], 1'b0};
            wdata_s = {2{WriteData[15:0]}};
         end
         default: begin
            be_s    = 4'b1111;
            wdata_s = WriteData;
         end
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   // Misalignment detection for the incoming access.
   always_comb begin
      case (funct3)
         3'b000, 3'b100: misalign_s = 1'b0;
         3'b001, 3'b101: misalign_s = ALUResult[0];
         default:        misalign_s = |ALUResult[1:0];
      endcase
   end
`else
   assign misalign_s = 1'b0;
`endif

   // Next-state and BUSY cycle counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_s) begin
               cnt_d   = 8'd0;
               state_d = misalign_s ? RESP : BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (MemReady || timeout_s) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM state plus the access latched at accept, held stable for the whole BUSY phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         lane_q  <= 2'd0;
         f3_q    <= 3'd0;
         load_q  <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept_s) begin
            lane_q  <= ALUResult[1:0];
            f3_q    <= funct3;
            load_q  <= !MemWrite;
            addr_q  <= {ALUResult[31:2], 2'b00};
            wdata_q <= wdata_s;
            be_q    <= be_s;
            we_q    <= MemWrite && !misalign_s;
         end else if (done_s || timeout_s) begin
            we_q <= 1'b0;
         end else begin
            we_q <= we_q;
         end
      end
   end

   // Load result and completion/error pulses, all launched into the RESP cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q  <= 32'd0;
         lv_q     <= 1'b0;
         buserr_q <= 1'b0;
      end else begin
         lv_q     <= done_s && load_q;
         buserr_q <= timeout_s;
         if (done_s && load_q) begin
            rdata_q <= extend_load(MemRData, lane_q, f3_q);
         end else if ((timeout_s && load_q) || (accept_s && misalign_s && !MemWrite)) begin
            rdata_q <= 32'd0;
         end else begin
            rdata_q <= rdata_q;
         end
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic mis_q;

   // Misalignment pulse lands in the RESP cycle that directly follows the accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= accept_s && misalign_s;
      end
   end
   assign MisalignErr = mis_q;
`else
   assign MisalignErr = 1'b0;
`endif

   assign Stall     = !rst && (accept_s || (state_q == BUSY));
   assign MemReq    = (state_q == BUSY);
   assign ReadData  = rdata_q;
   assign LoadValid = lv_q;
   assign BusErr    = buserr_q;
   assign MemAddr   = addr_q;
   assign MemWData  = wdata_q;
   assign MemBE     = be_q;
   assign MemWE     = we_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: directed scenarios plus randomized accesses against a reference model.
// Build with LSU_MISALIGN_TRAP_EN defined to exercise the misaligned-access trap.
module tb_lsu_stage;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ALUResult, WriteData, MemRData;
   logic        MemRead, MemWrite, MemReady;
   logic [2:0]  funct3;
   logic        Stall, LoadValid, MisalignErr, BusErr, MemWE, MemReq;
   logic [31:0] ReadData, MemAddr, MemWData;
   logic [3:0]  MemBE;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] model_rdata;

   // observations from the most recent run_access
   int          obs_req, obs_stall;
   logic [31:0] obs_addr, obs_wdata, obs_rdata;
   logic [3:0]  obs_be;
   logic        obs_we, obs_lv, obs_berr, obs_mis, obs_stall_resp;
   bit          obs_stable, obs_hung;

   always #5 clk = ~clk;

   lsu_stage #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .ALUResult(ALUResult), .WriteData(WriteData),
      .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3), .Stall(Stall),
      .ReadData(ReadData), .LoadValid(LoadValid), .MisalignErr(MisalignErr), .BusErr(BusErr),
      .MemAddr(MemAddr), .MemWData(MemWData), .MemBE(MemBE), .MemWE(MemWE), .MemReq(MemReq),
      .MemReady(MemReady), .MemRData(MemRData)
   );

   // ---------------- reference model ----------------
   function automatic int size_of(input logic [2:0] f3);
      if (f3 == 3'b000 || f3 == 3'b100) return 1;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
      return 4;
   endfunction

   function automatic int offset_of(input logic [2:0] f3, input logic [31:0] a);
      int sz = size_of(f3);
      return (int'(a[1:0]) / sz) * sz;
   endfunction

   function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [31:0] a);
      int sz = size_of(f3);
      return 4'(((1 << sz) - 1) << offset_of(f3, a));
   endfunction

   function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      int sz = size_of(f3);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] load_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] mem);
      longint m, v, full;
      int sz = size_of(f3);
      m    = longint'({32'd0, mem});
      full = longint'(1) << (8 * sz);
      v    = (m >> (8 * offset_of(f3, a))) & (full - 1);
      if ((f3 == 3'b000 || f3 == 3'b001) && v >= (full >> 1)) v = v - full;
      return 32'(v);
   endfunction

   // Drives one access; MemReady pulses in BUSY cycle number `delay` (0 = first, negative = never).
   task automatic run_access(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd, input int delay);
      int k;
      @(negedge clk);
      MemWrite  = wr;
      MemRead   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      ALUResult = addr; WriteData = wd; funct3 = f3; MemReady = 1'b0;
      #1;
      obs_stall = (Stall === 1'b1) ? 1 : 0;
      obs_req = 0; obs_stable = 1'b1;
      obs_addr = 32'd0; obs_wdata = 32'd0; obs_be = 4'd0; obs_we = 1'b0;
      @(posedge clk); @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0;
      ALUResult = $urandom; WriteData = $urandom; funct3 = 3'($urandom);
      #1;
      k = 0;
      while (MemReq === 1'b1 && k < 300) begin
         if (k == 0) begin
            obs_addr = MemAddr; obs_wdata = MemWData; obs_be = MemBE; obs_we = MemWE;
         end else if (MemAddr !== obs_addr || MemWData !== obs_wdata || MemBE !== obs_be || MemWE !== obs_we) begin
            obs_stable = 1'b0;
         end
         if (Stall === 1'b1) obs_stall++;
         obs_req++;
         MemReady = (k == delay);
         MemRData = (k == delay) ? rd : $urandom;
         @(posedge clk); @(negedge clk);
         MemReady = 1'b0;
         #1;
         k++;
      end
      obs_hung = (k >= 300);
      obs_lv = LoadValid; obs_berr = BusErr; obs_mis = MisalignErr;
      obs_rdata = ReadData; obs_stall_resp = Stall;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MemReady = 1'b0;
      ALUResult = 32'd0; WriteData = 32'd0; MemRData = 32'd0; funct3 = 3'd0;
      repeat (2) @(negedge clk);
      MemRead = 1'b1; ALUResult = 32'hFFFF_FFFF;
      #1;
      n_checks++; if (Stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", Stall); else n_pass++;
      n_checks++; if (MemReq !== 1'b0) $display("FAIL reset_memreq got=%b exp=0", MemReq); else n_pass++;
      n_checks++; if (MemWE !== 1'b0) $display("FAIL reset_memwe got=%b exp=0", MemWE); else n_pass++;
      n_checks++; if (MemBE !== 4'd0) $display("FAIL reset_membe got=%b exp=0000", MemBE); else n_pass++;
      n_checks++; if (MemAddr !== 32'd0) $display("FAIL reset_memaddr got=%h exp=0", MemAddr); else n_pass++;
      n_checks++; if (MemWData !== 32'd0) $display("FAIL reset_memwdata got=%h exp=0", MemWData); else n_pass++;
      n_checks++; if (ReadData !== 32'd0) $display("FAIL reset_readdata got=%h exp=0", ReadData); else n_pass++;
      n_checks++; if (LoadValid !== 1'b0) $display("FAIL reset_loadvalid got=%b exp=0", LoadValid); else n_pass++;
      n_checks++; if (BusErr !== 1'b0) $display("FAIL reset_buserr got=%b exp=0", BusErr); else n_pass++;
      n_checks++; if (MisalignErr !== 1'b0) $display("FAIL reset_misalign got=%b exp=0", MisalignErr); else n_pass++;
      MemRead = 1'b0;
      @(negedge clk); rst = 1'b0;
      model_rdata = 32'd0;
   endtask

   task automatic test_lb_signed;
      run_access(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 0);
      n_checks++; if (obs_be !== 4'b1000) $display("FAIL lb_be got=%b exp=1000", obs_be); else n_pass++;
      n_checks++; if (obs_addr !== 32'h0000_1000) $display("FAIL lb_addr got=%h exp=00001000", obs_addr); else n_pass++;
      n_checks++; if (obs_rdata !== 32'hFFFF_FF80) $display("FAIL lb_rdata got=%h exp=ffffff80", obs_rdata); else n_pass++;
      n_checks++; if (obs_lv !== 1'b1) $display("FAIL lb_loadvalid got=%b exp=1", obs_lv); else n_pass++;
      n_checks++; if (obs_req !== 1) $display("FAIL lb_latency got=%0d exp=1", obs_req); else n_pass++;
      n_checks++; if (obs_stall !== 2) $display("FAIL lb_stall_cycles got=%0d exp=2", obs_stall); else n_pass++;
      n_checks++; if (obs_stall_resp !== 1'b0) $display("FAIL lb_stall_resp got=%b exp=0", obs_stall_resp); else n_pass++;
      model_rdata = 32'hFFFF_FF80;
   endtask

   task automatic test_lhu_wait;
      run_access(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 2);
      n_checks++; if (obs_be !== 4'b1100) $display("FAIL lhu_be got=%b exp=1100", obs_be); else n_pass++;
      n_checks++; if (obs_rdata !== 32'h0000_BEEF) $display("FAIL lhu_rdata got=%h exp=0000beef", obs_rdata); else n_pass++;
      n_checks++; if (obs_stall !== 4) $display("FAIL lhu_stall_cycles got=%0d exp=4", obs_stall); else n_pass++;
      n_checks++; if (obs_stable !== 1'b1) $display("FAIL lhu_stable got=%b exp=1", obs_stable); else n_pass++;
      n_checks++; if (obs_lv !== 1'b1 || obs_berr !== 1'b0) $display("FAIL lhu_pulses got=%b%b exp=10", obs_lv, obs_berr); else n_pass++;
      model_rdata = 32'h0000_BEEF;
   endtask

   task automatic test_store_byte;
      run_access(1'b1, 3'b000, 32'h0000_0001, 32'h1234_56AB, 32'hDEAD_DEAD, 0);
      n_checks++; if (obs_we !== 1'b1) $display("FAIL sb_we got=%b exp=1", obs_we); else n_pass++;
      n_checks++; if (obs_be !== 4'b0010) $display("FAIL sb_be got=%b exp=0010", obs_be); else n_pass++;
      n_checks++; if (obs_wdata !== 32'hABAB_ABAB) $display("FAIL sb_wdata got=%h exp=abababab", obs_wdata); else n_pass++;
      n_checks++; if (obs_rdata !== model_rdata) $display("FAIL sb_rdata_held got=%h exp=%h", obs_rdata, model_rdata); else n_pass++;
      n_checks++; if (obs_lv !== 1'b0) $display("FAIL sb_loadvalid got=%b exp=0", obs_lv); else n_pass++;
   endtask

   task automatic test_timeout;
      logic [31:0] rd;
      run_access(1'b0, 3'b010, 32'h0000_0004, 32'h0, 32'h5555_AAAA, -1);
      n_checks++; if (obs_req !== TO) $display("FAIL to_req_cycles got=%0d exp=%0d", obs_req, TO); else n_pass++;
      n_checks++; if (obs_berr !== 1'b1) $display("FAIL to_buserr got=%b exp=1", obs_berr); else n_pass++;
      n_checks++; if (obs_lv !== 1'b0) $display("FAIL to_loadvalid got=%b exp=0", obs_lv); else n_pass++;
      n_checks++; if (obs_rdata !== 32'd0) $display("FAIL to_rdata got=%h exp=0", obs_rdata); else n_pass++;
      rd = $urandom;
      run_access(1'b0, 3'b010, 32'h0000_0008, 32'h0, rd, TO - 1);
      n_checks++; if (obs_req !== TO) $display("FAIL to_edge_req got=%0d exp=%0d", obs_req, TO); else n_pass++;
      n_checks++; if (obs_berr !== 1'b0 || obs_lv !== 1'b1) $display("FAIL to_edge_pulses got=%b%b exp=01", obs_berr, obs_lv); else n_pass++;
      n_checks++; if (obs_rdata !== rd) $display("FAIL to_edge_rdata got=%h exp=%h", obs_rdata, rd); else n_pass++;
      model_rdata = rd;
   endtask

   task automatic test_misalign;
      run_access(1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'hCAFE_F00D, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      n_checks++; if (obs_req !== 0) $display("FAIL mis_memreq got=%0d exp=0", obs_req); else n_pass++;
      n_checks++; if (obs_mis !== 1'b1) $display("FAIL mis_pulse got=%b exp=1", obs_mis); else n_pass++;
      n_checks++; if (obs_lv !== 1'b0) $display("FAIL mis_loadvalid got=%b exp=0", obs_lv); else n_pass++;
      n_checks++; if (obs_rdata !== 32'd0) $display("FAIL mis_rdata got=%h exp=0", obs_rdata); else n_pass++;
      model_rdata = 32'd0;
`else
      n_checks++; if (obs_addr !== 32'h0000_0004) $display("FAIL mis_addr got=%h exp=00000004", obs_addr); else n_pass++;
      n_checks++; if (obs_mis !== 1'b0) $display("FAIL mis_pulse got=%b exp=0", obs_mis); else n_pass++;
      n_checks++; if (obs_lv !== 1'b1) $display("FAIL mis_loadvalid got=%b exp=1", obs_lv); else n_pass++;
      n_checks++; if (obs_rdata !== 32'hCAFE_F00D) $display("FAIL mis_rdata got=%h exp=cafef00d", obs_rdata); else n_pass++;
      model_rdata = 32'hCAFE_F00D;
`endif
   endtask

   task automatic test_reset_busy;
      int highs;
      @(negedge clk);
      MemWrite = 1'b1; MemRead = 1'b0; funct3 = 3'b010; ALUResult = 32'h0000_0010; WriteData = $urandom;
      @(posedge clk); @(negedge clk);
      MemWrite = 1'b0; MemReady = 1'b0;
      @(posedge clk); @(negedge clk);
      #1;
      n_checks++; if (MemReq !== 1'b1) $display("FAIL rstbusy_pre_req got=%b exp=1", MemReq); else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++; if (MemReq !== 1'b0) $display("FAIL rstbusy_req_drop got=%b exp=0", MemReq); else n_pass++;
      n_checks++; if (Stall !== 1'b0 || MemWE !== 1'b0) $display("FAIL rstbusy_stall_we got=%b%b exp=00", Stall, MemWE); else n_pass++;
      @(negedge clk); rst = 1'b0;
      model_rdata = 32'd0;
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         MemReady = i[0];
         #1;
         if (BusErr !== 1'b0 || LoadValid !== 1'b0 || MemReq !== 1'b0 || Stall !== 1'b0) highs++;
         @(negedge clk);
      end
      MemReady = 1'b0;
      n_checks++; if (highs !== 0) $display("FAIL rstbusy_after got=%0d exp=0", highs); else n_pass++;
      n_checks++; if (ReadData !== 32'd0) $display("FAIL rstbusy_rdata got=%h exp=0", ReadData); else n_pass++;
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h0000_0040;
      MemReady = 1'b1; MemRData = 32'h1111_2222;
      #1;
      n_checks++; if (Stall !== 1'b1) $display("FAIL b2b_accept_stall got=%b exp=1", Stall); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (MemReq !== 1'b1 || Stall !== 1'b1) $display("FAIL b2b_busy got=%b%b exp=11", MemReq, Stall); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (MemReq !== 1'b0 || Stall !== 1'b0 || LoadValid !== 1'b1) $display("FAIL b2b_resp got=%b%b%b exp=001", MemReq, Stall, LoadValid); else n_pass++;
      n_checks++; if (ReadData !== 32'h1111_2222) $display("FAIL b2b_rdata1 got=%h exp=11112222", ReadData); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (Stall !== 1'b1 || MemReq !== 1'b0 || LoadValid !== 1'b0) $display("FAIL b2b_reaccept got=%b%b%b exp=100", Stall, MemReq, LoadValid); else n_pass++;
      @(negedge clk);
      MemRead = 1'b0; MemRData = 32'h3333_4444;
      #1;
      n_checks++; if (MemReq !== 1'b1) $display("FAIL b2b_busy2 got=%b exp=1", MemReq); else n_pass++;
      @(negedge clk);
      MemReady = 1'b0;
      #1;
      n_checks++; if (ReadData !== 32'h3333_4444 || LoadValid !== 1'b1) $display("FAIL b2b_rdata2 got=%h/%b exp=33334444/1", ReadData, LoadValid); else n_pass++;
      model_rdata = 32'h3333_4444;
   endtask

   task automatic test_random;
      bit          wr, trapped, completes;
      logic [2:0]  f3;
      logic [31:0] a, wd, rd, exp_rdata;
      int          sel, dly, exp_req;
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom_range(0, 1)); f3 = 3'($urandom);
         a = $urandom; wd = $urandom; rd = $urandom;
         sel = $urandom_range(0, 9);
         dly = (sel < 7) ? $urandom_range(0, 3) : (sel == 7) ? TO - 1 : (sel == 8) ? TO : -1;
         trapped = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         trapped = (int'(a[1:0]) % size_of(f3)) != 0;
`endif
         completes = !trapped && dly >= 0 && dly < TO;
         exp_req   = trapped ? 0 : (completes ? dly + 1 : TO);
         exp_rdata = wr ? model_rdata : (completes ? load_of(f3, a, rd) : 32'd0);
         run_access(wr, f3, a, wd, rd, dly);
         n_checks++; if (obs_hung !== 1'b0 || obs_req !== exp_req) $display("FAIL rnd%0d_req got=%0d exp=%0d", i, obs_req, exp_req); else n_pass++;
         n_checks++; if (obs_stall !== exp_req + 1) $display("FAIL rnd%0d_stall got=%0d exp=%0d", i, obs_stall, exp_req + 1); else n_pass++;
         if (exp_req > 0) begin
            n_checks++; if (obs_addr !== {a[31:2], 2'b00}) $display("FAIL rnd%0d_addr got=%h exp=%h", i, obs_addr, {a[31:2], 2'b00}); else n_pass++;
            n_checks++; if (obs_be !== be_of(f3, a)) $display("FAIL rnd%0d_be got=%b exp=%b", i, obs_be, be_of(f3, a)); else n_pass++;
            n_checks++; if (obs_wdata !== wdata_of(f3, wd)) $display("FAIL rnd%0d_wdata got=%h exp=%h", i, obs_wdata, wdata_of(f3, wd)); else n_pass++;
            n_checks++; if (obs_we !== wr || obs_stable !== 1'b1) $display("FAIL rnd%0d_we_stable got=%b%b exp=%b1", i, obs_we, obs_stable, wr); else n_pass++;
         end
         n_checks++; if (obs_lv !== (completes && !wr)) $display("FAIL rnd%0d_lv got=%b exp=%b", i, obs_lv, completes && !wr); else n_pass++;
         n_checks++; if (obs_berr !== (!trapped && !completes)) $display("FAIL rnd%0d_berr got=%b exp=%b", i, obs_berr, !trapped && !completes); else n_pass++;
         n_checks++; if (obs_mis !== trapped) $display("FAIL rnd%0d_mis got=%b exp=%b", i, obs_mis, trapped); else n_pass++;
         n_checks++; if (obs_rdata !== exp_rdata) $display("FAIL rnd%0d_rdata got=%h exp=%h", i, obs_rdata, exp_rdata); else n_pass++;
         n_checks++; if (obs_stall_resp !== 1'b0) $display("FAIL rnd%0d_stall_resp got=%b exp=0", i, obs_stall_resp); else n_pass++;
         model_rdata = exp_rdata;
      end
   endtask

   initial begin
      test_reset();
      test_lb_signed();
      test_lhu_wait();
      test_store_byte();
      test_timeout();
      test_misalign();
      test_reset_busy();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
